// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Default raster timing for 800x600@60 Hz on a 40 MHz pixel clock.
// Holds the per-axis widths, the derived totals and the counter width.
// Every module of the timing slice imports this package. Module parameters
// default to these constants.
// -----------------------------------------------------------------------------
package vga_pkg;

  localparam int H_ACTIVE = 800;
  localparam int H_FP     = 40;
  localparam int H_SYNC   = 128;
  localparam int H_BP     = 88;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;  // 1056

  localparam int V_ACTIVE = 600;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 4;
  localparam int V_BP     = 23;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;  // 628

  // Must satisfy 2**CNT_W >= max(H_TOTAL, V_TOTAL).
  localparam int CNT_W    = 11;

endpackage

// File: rtl/vga_if_tim.sv
// -----------------------------------------------------------------------------
// vga_if_tim
// Raster timing bundle shared by every drawing stage.
//   hcount / vcount : pixel and line index of the current pixel
//   hsync  / vsync  : active-high sync pulses
//   hblnk  / vblnk  : blanking flags
// Modports: out (producer, vga_timing_gen), in (drawing stages).
// -----------------------------------------------------------------------------
interface vga_if_tim #(
  parameter int CNT_W = vga_pkg::CNT_W
);
  logic [CNT_W-1:0] hcount;
  logic [CNT_W-1:0] vcount;
  logic             hsync;
  logic             vsync;
  logic             hblnk;
  logic             vblnk;

  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk);
  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk);
endinterface

// File: rtl/vga_axis_cnt.sv
// -----------------------------------------------------------------------------
// vga_axis_cnt
// One raster axis: a 0..TOTAL-1 wrap counter with enable, a terminal-count
// output and registered blank/sync window flags.
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset
//   en     in   advance the counter this cycle
//   cnt    out  current count (registered)
//   tc     out  cnt is at TOTAL-1 (combinational from the register)
//   blnk   out  registered, cnt >= ACTIVE
//   sync   out  registered, ACTIVE+FP <= cnt < ACTIVE+FP+SYNC
// -----------------------------------------------------------------------------
module vga_axis_cnt #(
  parameter int CNT_W  = vga_pkg::CNT_W,
  parameter int ACTIVE = vga_pkg::H_ACTIVE,
  parameter int FP     = vga_pkg::H_FP,
  parameter int SYNC   = vga_pkg::H_SYNC,
  parameter int TOTAL  = vga_pkg::H_TOTAL
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             tc,
  output logic             blnk,
  output logic             sync
);

  // Window bounds carry one extra bit so an end bound equal to 2**CNT_W
  // still compares correctly.
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W:0]   BLNK_BEG = (CNT_W + 1)'(ACTIVE);
  localparam logic [CNT_W:0]   SYNC_BEG = (CNT_W + 1)'(ACTIVE + FP);
  localparam logic [CNT_W:0]   SYNC_END = (CNT_W + 1)'(ACTIVE + FP + SYNC);

  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W:0]   cnt_nxt_x;

  always_comb begin
    tc      = (cnt == LAST);
    cnt_nxt = cnt;
    if (en) begin
      cnt_nxt = tc ? '0 : cnt + CNT_W'(1);
    end
    cnt_nxt_x = {1'b0, cnt_nxt};
  end

  // Flags are computed from the next count so they register together with it
  // and describe the same pixel as the count they are sampled with.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      blnk <= 1'b0;
      sync <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      blnk <= (cnt_nxt_x >= BLNK_BEG);
      sync <= (cnt_nxt_x >= SYNC_BEG) && (cnt_nxt_x < SYNC_END);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Free-running raster timing generator at the head of the display pipeline;
// sole producer of vga_if_tim. All outputs are registered and mutually aligned.
// Ports:
//   clk          in   pixel clock
//   rst          in   asynchronous active-low reset
//   tim_if_out   out  vga_if_tim.out (hcount, vcount, hsync, vsync, hblnk, vblnk)
//   frame_start  out  one-cycle pulse when the raster wraps to (0,0)
//   frame_cnt    out  16-bit count of completed frames (wraps)
// Build option: define VGA_TIM_FRAME_CNT_EN to add frame_start / frame_cnt;
// without it those ports and their logic are absent.
// -----------------------------------------------------------------------------
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP     = vga_pkg::H_FP,
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BP     = vga_pkg::H_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP     = vga_pkg::V_FP,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BP     = vga_pkg::V_BP,
  parameter int CNT_W    = vga_pkg::CNT_W
) (
  input  logic        clk,
  input  logic        rst,
  vga_if_tim.out      tim_if_out
`ifdef VGA_TIM_FRAME_CNT_EN
  ,
  output logic        frame_start,
  output logic [15:0] frame_cnt
`endif
);

  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             h_tc;
  logic             h_blnk;
  logic             h_sync;
  logic             v_blnk;
  logic             v_sync;

  vga_axis_cnt #(
    .CNT_W  (CNT_W),
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .TOTAL  (HT)
  ) u_hcnt (
    .clk   (clk),
    .rst_n (rst),
    .en    (1'b1),
    .cnt   (h_cnt),
    .tc    (h_tc),
    .blnk  (h_blnk),
    .sync  (h_sync)
  );

`ifdef VGA_TIM_FRAME_CNT_EN
  logic v_tc;
`endif

  // The vertical axis only moves on the last pixel of a line, so vsync and
  // vblnk change with whole-line granularity.
  vga_axis_cnt #(
    .CNT_W  (CNT_W),
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .TOTAL  (VT)
  ) u_vcnt (
    .clk   (clk),
    .rst_n (rst),
    .en    (h_tc),
    .cnt   (v_cnt),
`ifdef VGA_TIM_FRAME_CNT_EN
    .tc    (v_tc),
`else
    .tc    (),
`endif
    .blnk  (v_blnk),
    .sync  (v_sync)
  );

  assign tim_if_out.hcount = h_cnt;
  assign tim_if_out.vcount = v_cnt;
  assign tim_if_out.hsync  = h_sync;
  assign tim_if_out.vsync  = v_sync;
  assign tim_if_out.hblnk  = h_blnk;
  assign tim_if_out.vblnk  = v_blnk;

`ifdef VGA_TIM_FRAME_CNT_EN
  // Both axes at their last position means the next edge lands on (0,0)
  // through a wrap; the reset state itself never raises frame_start.
  logic frame_wrap;
  assign frame_wrap = h_tc & v_tc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      frame_start <= frame_wrap;
      if (frame_wrap) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
